text_memory_arbiter: RTL

- Shares the single-port synchronous text memory between two requesters: instruction fetch (IF) and a data-side read port (DM).
- The DM port serves loads of constant tables (AES S-box, round constants) placed in .text.
- Sits between the core's fetch/load units and the text memory macro; replaces direct wiring of the text memory bus.
- Handles arbitration, range/alignment checking, a fixed one-cycle response latency and DM starvation protection.

---
 rtl/text_bus_pkg.sv | 23 ++
 rtl/text_addr_check.sv | 15 +
 rtl/text_memory_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/text_bus_pkg.sv
// Shared types and build defaults for the text memory bus.
// TEXT_LOAD_PORT_EN adds the LD owner state.
package text_bus_pkg;

  localparam int unsigned STARVE_W = 4;

  localparam logic [31:0] TEXT_BEGIN_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] TEXT_END_DEFAULT   = 32'h0000_03FF;
  localparam int unsigned TEXT_BITS_DEFAULT  = 12;

`ifdef TEXT_LOAD_PORT_EN
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_LD} owner_e;
`else
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;
`endif

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } text_rsp_t;

endpackage

// File: rtl/text_addr_check.sv
// Combinational range and word-alignment check of a byte address against
// the text segment bounds.
module text_addr_check #(
    parameter logic [31:0] BEGIN_ADDR = 32'h0000_0000,
    parameter logic [31:0] END_ADDR   = 32'hFFFF_FFFF
) (
    input  logic [31:0] addr,
    output logic        in_range,
    output logic        aligned
);

    assign in_range = (addr >= BEGIN_ADDR) && (addr <= END_ADDR);
    assign aligned  = (addr[1:0] == 2'b00);

endmodule

// File: rtl/text_memory_arbiter.sv
// Arbitrates the single-port synchronous text memory between instruction
// fetch (IF) and a data-side read port (DM). Fixed one-cycle response
// latency, range/alignment errors and DM starvation protection.
// Optional macro TEXT_LOAD_PORT_EN adds a highest-priority write (load) port.
module text_memory_arbiter
    import text_bus_pkg::*;
#(
    parameter logic [31:0] TEXT_BEGIN = TEXT_BEGIN_DEFAULT,
    parameter logic [31:0] TEXT_END   = TEXT_END_DEFAULT,
    parameter int unsigned TEXT_BITS  = TEXT_BITS_DEFAULT,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_req_valid,
    input  logic [31:0]          if_req_addr,
    output logic                 if_req_ready,
    output logic                 if_rsp_valid,
    output logic [31:0]          if_rsp_data,
    output logic                 if_rsp_err,
    input  logic                 dm_req_valid,
    input  logic [31:0]          dm_req_addr,
    output logic                 dm_req_ready,
    output logic                 dm_rsp_valid,
    output logic [31:0]          dm_rsp_data,
    output logic                 dm_rsp_err,
    output logic [TEXT_BITS-3:0] mem_address,
    input  logic [31:0]          mem_q
`ifdef TEXT_LOAD_PORT_EN
    ,
    input  logic                 ld_valid,
    input  logic [31:0]          ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 ld_ready,
    output logic                 mem_wren,
    output logic [31:0]          mem_data
`endif
);

    logic                 if_in_range, if_aligned;
    logic                 dm_in_range, dm_aligned;
    logic                 if_grant, dm_grant;
    logic                 starve_full;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    owner_e               owner_q, owner_d;
    logic                 err_q, err_d;
    logic [TEXT_BITS-3:0] addr_q, addr_d;
    text_rsp_t            if_rsp, dm_rsp;
`ifdef TEXT_LOAD_PORT_EN
    logic                 ld_in_range, ld_aligned_unused;
    logic                 ld_grant;
`endif

    text_addr_check #(.BEGIN_ADDR(TEXT_BEGIN), .END_ADDR(TEXT_END)) u_if_check (
        .addr(if_req_addr), .in_range(if_in_range), .aligned(if_aligned)
    );

    text_addr_check #(.BEGIN_ADDR(TEXT_BEGIN), .END_ADDR(TEXT_END)) u_dm_check (
        .addr(dm_req_addr), .in_range(dm_in_range), .aligned(dm_aligned)
    );

`ifdef TEXT_LOAD_PORT_EN
    text_addr_check #(.BEGIN_ADDR(TEXT_BEGIN), .END_ADDR(TEXT_END)) u_ld_check (
        .addr(ld_addr), .in_range(ld_in_range), .aligned(ld_aligned_unused)
    );
`endif

    assign starve_full = (starve_q == STARVE_W'(MAX_STARVE));

    // Grant selection, memory address, next owner, error and starve count.
    always_comb begin
        if_grant = 1'b0;
        dm_grant = 1'b0;
        owner_d  = OWN_NONE;
        err_d    = 1'b0;
        addr_d   = addr_q;
`ifdef TEXT_LOAD_PORT_EN
        ld_grant = 1'b0;
`endif
        if (!reset) begin
`ifdef TEXT_LOAD_PORT_EN
            if (ld_valid) ld_grant = 1'b1;
            else
`endif
            if (dm_req_valid && starve_full) dm_grant = 1'b1;
            else if (if_req_valid)           if_grant = 1'b1;
            else if (dm_req_valid)           dm_grant = 1'b1;
        end

`ifdef TEXT_LOAD_PORT_EN
        if (ld_grant) begin
            owner_d = OWN_LD;
            addr_d  = ld_addr[TEXT_BITS-1:2];
        end else
`endif
        if (if_grant) begin
            owner_d = OWN_IF;
            addr_d  = if_req_addr[TEXT_BITS-1:2];
            err_d   = !(if_in_range && if_aligned);
        end else if (dm_grant) begin
            owner_d = OWN_DM;
            addr_d  = dm_req_addr[TEXT_BITS-1:2];
            err_d   = !(dm_in_range && dm_aligned);
        end

        if (reset) addr_d = '0;

        if (dm_req_valid && !dm_grant)
            starve_d = starve_full ? starve_q : starve_q + 1'b1;
        else
            starve_d = '0;
    end

    assign if_req_ready = if_grant;
    assign dm_req_ready = dm_grant;
    assign mem_address  = addr_d;

`ifdef TEXT_LOAD_PORT_EN
    assign ld_ready = ld_grant;
    assign mem_wren = ld_grant && ld_in_range;
    assign mem_data = ld_grant ? ld_data : '0;
`endif

    // Owner, error, held address and starve counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            addr_q   <= '0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            starve_q <= starve_d;
        end
    end

    // Route the memory read data to the owner of the previous cycle's grant.
    always_comb begin
        if_rsp = '0;
        dm_rsp = '0;
        if (!reset) begin
            if (owner_q == OWN_IF) begin
                if_rsp.valid = 1'b1;
                if_rsp.err   = err_q;
                if_rsp.data  = err_q ? '0 : mem_q;
            end
            if (owner_q == OWN_DM) begin
                dm_rsp.valid = 1'b1;
                dm_rsp.err   = err_q;
                dm_rsp.data  = err_q ? '0 : mem_q;
            end
        end
    end

    assign if_rsp_valid = if_rsp.valid;
    assign if_rsp_err   = if_rsp.err;
    assign if_rsp_data  = if_rsp.data;
    assign dm_rsp_valid = dm_rsp.valid;
    assign dm_rsp_err   = dm_rsp.err;
    assign dm_rsp_data  = dm_rsp.data;

endmodule
